// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-memory loader and its helpers.
//   load_state_e   : load FSM states (IDLE, RECV, WRITE, CHECK, DONE)
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   INSTR_W        : instruction word width in bits
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } load_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream input and instruction-memory write bus of the loader.
//   byte_valid/byte_data/byte_ready : valid/ready byte stream into the loader
//   mem_we/mem_waddr/mem_wdata      : word write port into instruction memory
// Modports:
//   master : stream producer / memory side (drives the byte stream)
//   slave  : the loader (accepts bytes, drives the memory write port)
// -----------------------------------------------------------------------------
interface imem_loader_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = INSTR_W
);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs stream bytes big-endian into instruction words and keeps a running
// XOR checksum over every byte shifted in.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart word, byte count and checksum (start of a load)
//   shift     : accept byte_in this cycle
//   byte_in   : stream byte
//   word_next : word formed by the held bytes plus byte_in in the low byte
//   word_full : three bytes held, so the next accepted byte completes a word
//   chk       : XOR of all bytes shifted in since the last clear
// -----------------------------------------------------------------------------
module word_assembler
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_next,
    output logic               word_full,
    output logic [7:0]         chk
);

    // Only the three older bytes need storage: the fourth is taken straight
    // from the stream so the finished word is available on its accept edge.
    logic [INSTR_W-9:0] shreg_q;
    logic [1:0]         byte_cnt_q;
    logic [7:0]         chk_q;

    assign word_next = {shreg_q, byte_in};
    assign word_full = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    assign chk       = chk_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            chk_q      <= '0;
        end else if (clear) begin
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            chk_q      <= '0;
        end else if (shift) begin
            shreg_q    <= word_next[INSTR_W-9:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;   // wraps to 0 after the 4th byte
            chk_q      <= chk_q ^ byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program from a byte stream into instruction memory, one big-endian
// 32-bit word per consecutive word address, while holding the core in reset.
// A trailing XOR checksum byte must match before the core is released.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle pulse; begins a load from IDLE or DONE
//   num_words  : words to load, sampled on an accepted start
//   bus        : byte stream in, memory write port out (slave modport)
//   core_rst   : registered core reset, high except after a verified load
//   busy       : load in progress (RECV, WRITE, CHECK)
//   done       : load finished; held until the next start
//   err        : checksum mismatch, valid while done is high
// -----------------------------------------------------------------------------
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    imem_loader_if.slave      bus,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] num_words_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q, err_d;
    logic              core_rst_q;

    logic              byte_ready;
    logic              accept;
    logic              load_start;
    logic              shift;
    logic              wr_capture;
    logic              idx_inc;
    logic              last_word;

    logic [INSTR_W-1:0] asm_word;
    logic               asm_full;
    logic [7:0]         asm_chk;

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_start),
        .shift     (shift),
        .byte_in   (bus.byte_data),
        .word_next (asm_word),
        .word_full (asm_full),
        .chk       (asm_chk)
    );

    assign accept    = bus.byte_valid && byte_ready;
    // num_words_q is never zero outside IDLE/DONE, so the subtraction cannot wrap.
    assign last_word = (word_idx_q == num_words_q - 1'b1);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        byte_ready = 1'b0;
        load_start = 1'b0;
        shift      = 1'b0;
        wr_capture = 1'b0;
        idx_inc    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_start = 1'b1;
                    err_d      = 1'b0;
                    state_d    = (num_words == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (accept) begin
                    shift = 1'b1;
                    if (asm_full) begin
                        wr_capture = 1'b1;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = CHECK;
                end else begin
                    idx_inc = 1'b1;
                    state_d = RECV;
                end
            end
            CHECK: begin
                byte_ready = 1'b1;
                if (accept) begin
                    err_d   = (bus.byte_data != asm_chk);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            num_words_q <= '0;
            word_idx_q  <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            // Core is released only in DONE with a good checksum.
            core_rst_q <= (state_d == DONE) ? err_d : 1'b1;

            if (load_start) begin
                num_words_q <= num_words;
                word_idx_q  <= '0;
            end else if (idx_inc) begin
                word_idx_q <= word_idx_q + 1'b1;
            end

            // Address and word are captured on the 4th-byte edge so they are
            // stable for the WRITE cycle and then hold until the next word.
            if (wr_capture) begin
                waddr_q <= word_idx_q;
                wdata_q <= DATA_W'(asm_word);
            end
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;

    assign core_rst = core_rst_q;
    assign busy     = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory read path used by the datapath. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes each word into instruction memory at consecutive word addresses, the same word indexing the fetch path uses after the PC divide-by-4. It holds the core in reset during loading and releases it only after a trailing XOR checksum byte verifies.

Parameters:
ADDR_W, 8, width of the word address and of the word count
DATA_W, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load (honoured only in IDLE or DONE)
num_words  in  ADDR_W  number of words to load; sampled on an accepted start
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts a byte this cycle
mem_we  out  1  instruction-memory write strobe, one cycle per word
mem_waddr  out  ADDR_W  word address
mem_wdata  out  32  instruction word
core_rst  out  1  holds PC/core in reset while high
busy  out  1  load in progress
done  out  1  load finished (success or error); level, held until next start
err  out  1  checksum mismatch; valid while done=1

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_rst=1, busy=0, done=0, err=0; state=IDLE.
- A byte transfer occurs only on a clk edge where byte_valid && byte_ready. byte_data is ignored otherwise.
- States:
  - IDLE: byte_ready=0, core_rst=1. On start: latch num_words, clear word_idx, byte_cnt and chk. If num_words==0, go to DONE with err=0, no writes and no checksum byte. Otherwise go to RECV with busy=1.
  - RECV: byte_ready=1. Each accepted byte shifts into the word, MSB first: the first byte goes to [31:24] and the fourth to [7:0]. Each accepted byte is also folded in with chk ^= byte. When the 4th byte is accepted, go to WRITE.
  - WRITE: exactly one cycle. mem_we=1, mem_waddr=word_idx, mem_wdata=assembled word, byte_ready=0. If word_idx==num_words-1, go to CHECK. Otherwise increment word_idx and return to RECV.
  - CHECK: byte_ready=1. The accepted byte is compared with chk. Go to DONE with err=(byte!=chk).
  - DONE: busy=0, done=1, byte_ready=0. core_rst=err, so the core stays held on error. A start here clears done/err, reasserts core_rst=1 and behaves as in IDLE.
- Latency: 4th byte accepted on edge N gives mem_we=1 during cycle N+1. Minimum load time is 5*num_words+1 cycles when byte_valid is held high.
- start while busy (RECV, WRITE or CHECK) is ignored; num_words is not re-sampled.
- byte_valid low stalls the FSM in RECV/CHECK indefinitely. There is no timeout.
- mem_waddr holds its last value while mem_we=0. mem_wdata holds the last written word.
- num_words = 2^ADDR_W-1 is the maximum. word_idx never wraps because the last index is checked before incrementing.
- Asynchronous reset mid-load returns to the reset state immediately. No further writes occur, core_rst=1, and partial memory contents are left as is.
- core_rst is registered and never glitches.

Decomposition:
- Shared package cpu_pkg: the load FSM state enum (IDLE, RECV, WRITE, CHECK, DONE), the bytes-per-word constant 4, and the instruction width 32.
- Sub-module: word_assembler. It contains the 4-byte shift register, the 2-bit byte counter, the word_full flag, and the running XOR checksum with a clear input. The FSM stays in imem_loader.

Test Plan:
1. Reset held, then released with no start -> core_rst=1, busy=0, done=0, byte_ready=0, mem_we=0 for 20 cycles.
2. start, num_words=2, bytes 8C 01 00 04 20 22 00 01 and checksum 0x8A (XOR of all eight bytes), byte_valid held high -> mem_we writes 0x8C010004@0 then 0x20220001@1, each one cycle after the 4th byte; then done=1, err=0, core_rst=0.
3. Same stream as scenario 2 but checksum 0x00 -> both words written, done=1, err=1, core_rst stays 1.
4. num_words=1 with byte_valid toggling every other cycle, plus a start pulse mid-stream -> the extra start is ignored; word DEADBEEF written at address 0; checksum 0x22 gives done=1, err=0.
5. num_words=0 on start -> next cycle done=1, err=0, core_rst=0, no mem_we pulse, byte_ready never asserted.
6. Reset asserted after 2 bytes of word 3 in a 5-word load -> all outputs at reset values immediately. A new start with num_words=1 loads cleanly to address 0.
